// File: rtl/div_result_fifo.sv
// Result buffer behind the signed divider. Each quotient beat is arithmetic-
// shifted and saturated to OUT_W bits, then queued in a first-word-fall-through
// FIFO. The divider cannot be stalled, so a beat that arrives while the FIFO is
// full and not draining is dropped, and the sticky overflow flag is raised.
//
// Output handshake: out_valid means the head entry on out_data/out_sat is
// meaningful. The head is consumed on a rising edge where out_valid and
// out_ready are both 1. out_data/out_sat stay stable until that happens.
// out_ready is ignored while out_valid is 0.
module div_result_fifo #(
    parameter int DEPTH     = 8,
    parameter int OUT_W     = 16,
    parameter int SHIFT     = 0,
    parameter int AF_MARGIN = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       quo_valid,
    input  logic [39:0]                quo_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic                       out_sat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full,
    output logic                       overflow
);

    localparam int PW       = $clog2(DEPTH);
    localparam int CW       = PW + 1;
    localparam int AF_LEVEL = DEPTH - AF_MARGIN;
    // With a zero threshold the flag is high even with an empty FIFO.
    localparam logic AF_RESET = (AF_LEVEL <= 0);

    // Saturation bounds in the 40-bit quotient domain. For OUT_W = 40 the
    // shift wraps, which still yields the correct full-width bounds.
    localparam logic signed [39:0] SAT_MAX = (40'sd1 <<< (OUT_W - 1)) - 40'sd1;
    localparam logic signed [39:0] SAT_MIN = -(40'sd1 <<< (OUT_W - 1));

    // Each entry holds {sat, data}.
    logic [OUT_W:0]     mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count_next;

    logic signed [39:0] shifted;
    logic [OUT_W-1:0]   conv_data;
    logic               conv_sat;

    logic               pop;
    logic               full;
    logic               wr_en;
    logic               drop;

    // Shift and clamp the incoming quotient into the narrow output format.
    always_comb begin
        shifted   = $signed(quo_data) >>> SHIFT;
        conv_data = shifted[OUT_W-1:0];
        conv_sat  = 1'b0;
        if (shifted > SAT_MAX) begin
            conv_data = {1'b0, {(OUT_W-1){1'b1}}};
            conv_sat  = 1'b1;
        end else if (shifted < SAT_MIN) begin
            conv_data = {1'b1, {(OUT_W-1){1'b0}}};
            conv_sat  = 1'b1;
        end
    end

    // Handshake decode: a full FIFO still accepts a beat when the head leaves
    // in the same cycle, since the freed slot is the one being written.
    always_comb begin
        pop   = out_valid & out_ready;
        full  = (count == CW'(DEPTH));
        wr_en = quo_valid & (~full | pop);
        drop  = quo_valid & full & ~pop;
        case ({wr_en, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage and pointers; reset clears the array so the head reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= {conv_sat, conv_data};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Occupancy and the status flags derived from it, all registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            out_valid   <= 1'b0;
            almost_full <= AF_RESET;
            overflow    <= 1'b0;
        end else begin
            count       <= count_next;
            out_valid   <= (count_next != '0);
            almost_full <= (int'(count_next) >= AF_LEVEL);
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Fall-through head: the entry at the read pointer is always visible.
    always_comb begin
        out_data = mem[rd_ptr][OUT_W-1:0];
        out_sat  = mem[rd_ptr][OUT_W];
    end

endmodule
